alu_arbiter: RTL and testbench

Shares a single `alu_unit` instance (ADD/SUB/AND/OR/XOR, 7-bit operands, 8-bit result) between two requesters in the pipelined core, for example the execute stage and the address-generation path. Each requester hands over an opcode and two operands with a valid/ready handshake. The block grants one requester at a time and drives the latched operands into the ALU. It returns the registered result, tagged with the requester ID, on a valid/ready response channel.

---
 rtl/alu_arbiter.sv | 120 ++++++++++++
 tb/tb_alu_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter that shares one ALU and returns a tagged, registered result.
// Ports: two req valid/ready ops, rsp valid/ready result; `ALU_ARB_RR_EN enables round-robin.
module alu_unit #(
    parameter int WIDTH    = 7,
    parameter int OP_WIDTH = 3
) (
    input  logic [OP_WIDTH-1:0] op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic [WIDTH:0]      result
);
    always_comb begin
        result = '0;
        case (op)
            OP_WIDTH'(1): result = {1'b0, a} + {1'b0, b};
            OP_WIDTH'(2): result = {1'b0, a} - {1'b0, b};
            OP_WIDTH'(3): result = {1'b0, a & b};
            OP_WIDTH'(4): result = {1'b0, a | b};
            OP_WIDTH'(5): result = {1'b0, a ^ b};
            default:      result = '0;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int WIDTH    = 7,
    parameter int OP_WIDTH = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    input  logic [OP_WIDTH-1:0] req0_op,
    input  logic [WIDTH-1:0]    req0_a,
    input  logic [WIDTH-1:0]    req0_b,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [OP_WIDTH-1:0] req1_op,
    input  logic [WIDTH-1:0]    req1_a,
    input  logic [WIDTH-1:0]    req1_b,
    output logic                req1_ready,
    output logic                rsp_valid,
    output logic                rsp_id,
    output logic [WIDTH:0]      rsp_data,
    input  logic                rsp_ready
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state;
    logic [OP_WIDTH-1:0] op_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic                id_q;
    logic [WIDTH:0]      alu_result;
    logic                grant0;
    logic                grant1;

`ifdef ALU_ARB_RR_EN
    logic prio;
    // prio names the requester that wins a tie
    assign grant1 = req1_valid & (~req0_valid | prio);
`else
    assign grant1 = req1_valid & ~req0_valid;
`endif
    assign grant0 = req0_valid & ~grant1;

    assign req0_ready = (state == IDLE) & grant0;
    assign req1_ready = (state == IDLE) & grant1;

    alu_unit #(.WIDTH(WIDTH), .OP_WIDTH(OP_WIDTH)) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
`ifdef ALU_ARB_RR_EN
            prio      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 | grant1) begin
                        op_q  <= grant1 ? req1_op : req0_op;
                        a_q   <= grant1 ? req1_a : req0_a;
                        b_q   <= grant1 ? req1_b : req0_b;
                        id_q  <= grant1;
`ifdef ALU_ARB_RR_EN
                        prio  <= ~grant1;
`endif
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_result;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    // no grant here: IDLE is always visited between operations
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed steps plus randomized transactions
// compared against a behavioural model of arbitration and ALU arithmetic.
module tb_alu_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0;
    logic [2:0] req0_op = '0;
    logic [6:0] req0_a = '0;
    logic [6:0] req0_b = '0;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [2:0] req1_op = '0;
    logic [6:0] req1_a = '0;
    logic [6:0] req1_b = '0;
    logic       req1_ready;
    logic       rsp_valid;
    logic       rsp_id;
    logic [7:0] rsp_data;
    logic       rsp_ready = 1'b1;

    int total = 0;
    int passed = 0;
    int m_prio = 0;

    alu_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_ready  (rsp_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int ref_alu(input int op, input int a, input int b);
        case (op)
            1: return a + b;
            2: return (a - b + 256) % 256;
            3: return a & b;
            4: return a | b;
            5: return a ^ b;
            default: return 0;
        endcase
    endfunction

    // Which requester should win given the valids; updates the model pointer.
    function automatic int pick(input int v0, input int v1);
        int w;
`ifdef ALU_ARB_RR_EN
        if (v0 != 0 && v1 != 0) w = m_prio;
        else w = (v1 != 0) ? 1 : 0;
        m_prio = 1 - w;
`else
        w = (v0 != 0) ? 0 : 1;
`endif
        return w;
    endfunction

    // Starts and ends at a negedge with the DUT in IDLE; at least one valid must be set.
    task automatic txn(input int v0, input int op0, input int a0, input int b0,
                       input int v1, input int op1, input int a1, input int b1,
                       input int stall, input string tag, output int win);
        int exp_d;
        req0_valid = v0[0]; req0_op = op0[2:0]; req0_a = a0[6:0]; req0_b = b0[6:0];
        req1_valid = v1[0]; req1_op = op1[2:0]; req1_a = a1[6:0]; req1_b = b1[6:0];
        rsp_ready = 1'b0;
        win = pick(v0, v1);
        exp_d = (win == 0) ? ref_alu(op0, a0, b0) : ref_alu(op1, a1, b1);
        #1;
        chk({tag, ".r0"}, req0_ready, win == 0);
        chk({tag, ".r1"}, req1_ready, win == 1);
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".exec_v"}, rsp_valid, 0);
        chk({tag, ".exec_rdy"}, {req0_ready, req1_ready}, 0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".v"}, rsp_valid, 1);
        chk({tag, ".d"}, rsp_data, exp_d);
        chk({tag, ".id"}, rsp_id, win);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, ".st_v"}, rsp_valid, 1);
            chk({tag, ".st_d"}, rsp_data, exp_d);
            chk({tag, ".st_id"}, rsp_id, win);
            chk({tag, ".st_rdy"}, {req0_ready, req1_ready}, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".done_v"}, rsp_valid, 0);
    endtask

    initial begin
        int w;
        int v0, v1;
        int wins [$];

        // reset state
        repeat (2) @(negedge clk);
        chk("rst.r0", req0_ready, 0);
        chk("rst.r1", req1_ready, 0);
        chk("rst.v", rsp_valid, 0);
        chk("rst.id", rsp_id, 0);
        chk("rst.d", rsp_data, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle.v", rsp_valid, 0);
        chk("idle.rdy", {req0_ready, req1_ready}, 0);

        // directed ALU cases
        txn(1, 1, 'h7F, 'h01, 0, 0, 0, 0, 0, "add", w);
        txn(0, 0, 0, 0, 1, 2, 3, 5, 0, "sub", w);
        txn(0, 0, 0, 0, 1, 7, 'h12, 'h34, 0, "op7", w);
        txn(1, 5, 'h55, 'h2A, 0, 0, 0, 0, 0, "xor", w);
        txn(1, 3, 'h7F, 'h0F, 0, 0, 0, 0, 0, "and", w);
        txn(1, 4, 'h40, 'h01, 0, 0, 0, 0, 0, "or", w);
        txn(1, 0, 'h11, 'h22, 0, 0, 0, 0, 5, "stall", w);

        // both requesters valid continuously
        for (int i = 0; i < 4; i++) begin
            txn(1, 1, i, 1, 1, 2, 9, i, 0, "both", w);
            wins.push_back(w);
        end
`ifdef ALU_ARB_RR_EN
        for (int i = 0; i < 4; i++) chk("both.seq", wins[i], wins[0] ^ (i % 2));
`else
        for (int i = 0; i < 4; i++) chk("both.seq", wins[i], 0);
`endif
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // reset mid-EXEC drops the operation
        req1_valid = 1'b1; req1_op = 3'd1; req1_a = 7'd9; req1_b = 7'd9;
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst.v", rsp_valid, 0);
        chk("mid_rst.d", rsp_data, 0);
        @(negedge clk);
        rst = 1'b0;
        m_prio = 0;
        repeat (2) @(negedge clk);
        chk("post_rst.v", rsp_valid, 0);
        chk("post_rst.id", rsp_id, 0);
        txn(1, 2, 10, 4, 0, 0, 0, 0, 0, "after_rst", w);
        txn(1, 1, 1, 1, 1, 1, 2, 2, 0, "after_rst_tie", w);

        // randomized transactions
        for (int i = 0; i < 30; i++) begin
            v0 = int'($urandom_range(0, 1));
            v1 = (v0 == 0) ? 1 : int'($urandom_range(0, 1));
            txn(v0, int'($urandom_range(0, 7)), int'($urandom_range(0, 127)),
                int'($urandom_range(0, 127)),
                v1, int'($urandom_range(0, 7)), int'($urandom_range(0, 127)),
                int'($urandom_range(0, 127)),
                int'($urandom_range(0, 2)), "rand", w);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
